dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data-memory port between two requesters: port 0, the pipeline memory stage, and port 1, a secondary master such as the boot loader or debug module. Each port uses a valid/ready request handshake. The arbiter drives the synchronous-read RAM and routes each 1-cycle-latency read response back to the port that issued it. Port 0 has fixed priority. An optional starvation guard bounds port 1 wait time, and port 1 may lock the memory for short bursts.

## Interface
- STARVE_LIMIT, 8: consecutive cycles port 1 may wait before it is forced a grant; range 1..255.
- LOCK_MAX, 4: maximum consecutive locked port-1 beats per lock; range 1..15.
- Clk  in  1  clock.
- Reset_n  in  1  reset, synchronous, active-low.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_addr / req1_addr  in  32  byte address.
- req0_wr_byte_en / req1_wr_byte_en  in  4  write byte enables; all-zero means read.
- req0_wr_data / req1_wr_data  in  32  write data, already lane-aligned.
- req1_lock  in  1  hold the grant for the next port-1 beat.
- rsp0_valid / rsp1_valid  out  1  read data valid.
- rsp0_rd_data / rsp1_rd_data  out  32  read data.
- mem_en  out  1  RAM access enable.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_wr_byte_en  out  4  RAM byte enables.
- mem_wr_data  out  32  RAM write data.
- mem_rd_data  in  32  RAM read data, valid one cycle after mem_en.

## Operation
- FSM with two states:
  - ARB_NORMAL: arbitrate each cycle.
  - ARB_LOCK1: port 1 owns the memory.
- ARB_NORMAL grant rules:
  - Grant port 0 if req0_valid, unless the forced grant is active.
  - Otherwise grant port 1 if req1_valid.
  - Forced grant is active when the starvation count equals STARVE_LIMIT and req1_valid is high.
- req*_ready for a port equals that port's grant.
- A transfer occurs on the cycle where valid and ready are both high.
- mem_en, mem_addr, mem_wr_byte_en and mem_wr_data are combinational from the granted port.
- When no port is granted: mem_en=0 and mem_wr_byte_en=0. mem_addr and mem_wr_data hold the port-0 values.
- Lock:
  - A port-1 transfer with req1_lock=1 moves the FSM from ARB_NORMAL to ARB_LOCK1 and clears the lock-beat counter.
  - In ARB_LOCK1, port 1 is the only granted port and port 0 sees ready=0.
  - Each port-1 transfer in ARB_LOCK1 increments the beat counter.
  - Return to ARB_NORMAL when req1_lock=0 on a transfer, when req1_valid=0, or when the counter reaches LOCK_MAX.
- Starvation counter (8-bit):
  - Increments while req1_valid=1 and port 1 is not granted.
  - Clears on any port-1 transfer or when req1_valid=0.
  - Saturates at STARVE_LIMIT.
- Response tracking:
  - A read transfer registers rd_owner (1 bit) and rd_pending=1.
  - On the next cycle, rsp<rd_owner>_valid=1 and rsp<rd_owner>_rd_data=mem_rd_data.
  - The other port sees rsp_valid=0 and rd_data=0.
  - Writes produce no response.
- Back-to-back reads are allowed every cycle and responses stay in issue order.
- Simultaneous req0_valid and req1_valid with no forced grant: port 0 wins and the port-1 count increments.

## Timing
- Request-to-ready path is combinational, so there are zero cycles of added latency on an uncontested grant.
- Read latency is 1 cycle from transfer to rsp_valid.
- Write completes on the transfer cycle.
- Reset values:
  - FSM = ARB_NORMAL.
  - Starvation count = 0, lock-beat counter = 0.
  - rd_pending = 0, rd_owner = 0.
  - rsp0_valid = 0, rsp1_valid = 0.
  - rsp0_rd_data = 0, rsp1_rd_data = 0.
  - mem_en = 0, req0_ready = 0, req1_ready = 0.
- Reset mid-operation: any pending response is dropped and rsp_valid is 0 in the cycle after reset is sampled.
- Ready must not depend on the same port's ready (no combinational loop).

## Configuration
- DMEM_ARB_STARVE_GUARD_EN defined: the starvation counter and forced grant are present.
  - The port-1 grant is guaranteed within STARVE_LIMIT+1 cycles of continuous req1_valid.
- Not defined: the counter is removed and arbitration is pure fixed priority.
  - Port 1 may starve indefinitely while req0_valid is held high.
  - The lock and response paths are unchanged.

## Structure
- Shared package RV32I_definitions gains:
  - typedef enum logic {ARB_NORMAL, ARB_LOCK1} dmem_arb_state_t;
  - localparam DMEM_ARB_PORTS = 2.
- One sub-module: dmem_arb_starve_cnt. It holds the saturating counter and forced-grant flag, and is instantiated only under DMEM_ARB_STARVE_GUARD_EN.

## Test plan
- Port 0 read addr 0x104 only -> req0_ready=1 same cycle, mem_addr=0x104, mem_en=1; next cycle rsp0_valid=1 with mem_rd_data; rsp1_valid=0.
- Both ports read continuously with guard on, STARVE_LIMIT=8 -> port 0 granted 8 cycles, port 1 granted on cycle 9 with count reset; repeat pattern 8:1.
- Same stimulus with guard macro undefined -> req1_ready stays 0 for 50 cycles.
- Port 1 write 0xDEADBEEF, byte_en=4'b1111, lock=1 for 6 beats with port 0 requesting, LOCK_MAX=4 -> req0_ready=0 for 4 beats; beat 5 returns to ARB_NORMAL and port 0 is granted.
- Alternating port-0 and port-1 reads every cycle -> responses arrive 1 cycle later on the matching rsp port in order; no misrouting.
- Reset_n=0 the cycle after a port-1 read transfer -> rsp1_valid=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/RV32I_definitions.sv
// Shared RV32I definitions used by the data-memory path.
// Contents:
//   dmem_arb_state_t  - arbiter FSM states (normal arbitration / port-1 locked)
//   DMEM_ARB_PORTS    - number of requesters sharing the data-memory port
//   dmem_word_addr()  - byte address to word-aligned RAM address
package RV32I_definitions;

  typedef enum logic {ARB_NORMAL, ARB_LOCK1} dmem_arb_state_t;

  localparam int DMEM_ARB_PORTS = 2;

  function automatic logic [31:0] dmem_word_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Port-1 starvation guard for dmem_arbiter.
// Counts consecutive cycles that port 1 has a request pending without being
// granted, saturating at STARVE_LIMIT, and raises force_gnt once the limit is
// reached while the request is still present.
// Ports:
//   Clk, Reset_n    clock, synchronous active-low reset
//   req1_valid      port-1 request present
//   req1_gnt        port 1 granted this cycle (grant implies a transfer)
//   force_gnt       port 1 must win arbitration this cycle
module dmem_arb_starve_cnt #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic req1_valid,
  input  logic req1_gnt,
  output logic force_gnt
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      starve_cnt <= 8'd0;
    end else if (!req1_valid || req1_gnt) begin
      starve_cnt <= 8'd0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Depends only on the registered count, so the grant path stays loop-free.
  assign force_gnt = req1_valid && (starve_cnt == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single synchronous-read data RAM.
// Port 0 (pipeline memory stage) has fixed priority over port 1 (boot loader /
// debug). Port 1 may lock the RAM for up to LOCK_MAX further beats. Read data
// returns one cycle after the transfer on the port that issued the read.
// Optional feature: define DMEM_ARB_STARVE_GUARD_EN to bound port-1 wait time
// to STARVE_LIMIT cycles via a forced grant; otherwise pure fixed priority.
// Ports:
//   Clk, Reset_n                      clock, synchronous active-low reset
//   reqN_valid / reqN_ready           request handshake, ready = grant
//   reqN_addr / _wr_byte_en / _wr_data request payload (byte_en 0 = read)
//   req1_lock                         keep port 1 owning the RAM
//   rspN_valid / rspN_rd_data         read response, zero when not valid
//   mem_*                             RAM port, mem_rd_data one cycle after mem_en
module dmem_arbiter
  import RV32I_definitions::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int LOCK_MAX     = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_addr,
  input  logic [3:0]  req0_wr_byte_en,
  input  logic [31:0] req0_wr_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_addr,
  input  logic [3:0]  req1_wr_byte_en,
  input  logic [31:0] req1_wr_data,
  input  logic        req1_lock,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rd_data,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rd_data,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wr_byte_en,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data
);

  localparam int         OWNER_W   = $clog2(DMEM_ARB_PORTS);
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_MAX - 1);

  dmem_arb_state_t      state;
  logic [3:0]           beat_cnt;
  logic                 rd_pending;
  logic [OWNER_W-1:0]   rd_owner;
  logic                 gnt0;
  logic                 gnt1;
  logic                 force_gnt;
  logic                 rd_xfer;

  // The RAM is word addressed; byte offsets are dropped on the way out.
  wire unused_addr_lsbs = ^{req0_addr[1:0], req1_addr[1:0]};

`ifdef DMEM_ARB_STARVE_GUARD_EN
  dmem_arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .req1_valid (req1_valid),
    .req1_gnt   (gnt1),
    .force_gnt  (force_gnt)
  );
`else
  // Without the guard the limit has no effect and port 1 can starve.
  wire unused_starve_limit = ^8'(STARVE_LIMIT);
  assign force_gnt = 1'b0;
`endif

  // Grants are held low while reset is asserted so the RAM sees no access.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (Reset_n) begin
      if (state == ARB_LOCK1) begin
        gnt1 = req1_valid;
      end else if (req0_valid && !force_gnt) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // With no grant, address and data follow port 0; enables stay low.
  assign mem_en         = gnt0 | gnt1;
  assign mem_addr       = gnt1 ? dmem_word_addr(req1_addr) : dmem_word_addr(req0_addr);
  assign mem_wr_data    = gnt1 ? req1_wr_data : req0_wr_data;
  assign mem_wr_byte_en = gnt0 ? req0_wr_byte_en : (gnt1 ? req1_wr_byte_en : 4'b0000);

  assign rd_xfer = mem_en && (mem_wr_byte_en == 4'b0000);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= ARB_NORMAL;
      beat_cnt   <= 4'd0;
      rd_pending <= 1'b0;
      rd_owner   <= '0;
    end else begin
      rd_pending <= rd_xfer;
      if (rd_xfer) begin
        rd_owner <= OWNER_W'(gnt1);
      end
      case (state)
        ARB_NORMAL: begin
          if (gnt1 && req1_lock) begin
            state    <= ARB_LOCK1;
            beat_cnt <= 4'd0;
          end
        end
        ARB_LOCK1: begin
          if (!req1_valid) begin
            state <= ARB_NORMAL;
          end else begin
            beat_cnt <= beat_cnt + 4'd1;
            // Leave on the beat that brings the count up to LOCK_MAX.
            if (!req1_lock || (beat_cnt == LOCK_LAST)) begin
              state <= ARB_NORMAL;
            end
          end
        end
        default: state <= ARB_NORMAL;
      endcase
    end
  end

  // Response stage: RAM data lands one cycle after the read transfer.
  assign rsp0_valid   = rd_pending && (rd_owner == OWNER_W'(0));
  assign rsp1_valid   = rd_pending && (rd_owner == OWNER_W'(1));
  assign rsp0_rd_data = rsp0_valid ? mem_rd_data : 32'd0;
  assign rsp1_rd_data = rsp1_valid ? mem_rd_data : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int STARVE_LIMIT = 8;
  localparam int LOCK_MAX     = 4;

  typedef struct {
    bit          v;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } req_t;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, req1_lock = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_addr = '0, req1_addr = '0, req0_wr_data = '0, req1_wr_data = '0;
  logic [3:0]  req0_wr_byte_en = '0, req1_wr_byte_en = '0;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rd_data, rsp1_rd_data;
  logic        mem_en;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic [3:0]  mem_wr_byte_en;

  dmem_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .LOCK_MAX     (LOCK_MAX)
  ) dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .req0_valid      (req0_valid),
    .req0_ready      (req0_ready),
    .req0_addr       (req0_addr),
    .req0_wr_byte_en (req0_wr_byte_en),
    .req0_wr_data    (req0_wr_data),
    .req1_valid      (req1_valid),
    .req1_ready      (req1_ready),
    .req1_addr       (req1_addr),
    .req1_wr_byte_en (req1_wr_byte_en),
    .req1_wr_data    (req1_wr_data),
    .req1_lock       (req1_lock),
    .rsp0_valid      (rsp0_valid),
    .rsp0_rd_data    (rsp0_rd_data),
    .rsp1_valid      (rsp1_valid),
    .rsp1_rd_data    (rsp1_rd_data),
    .mem_en          (mem_en),
    .mem_addr        (mem_addr),
    .mem_wr_byte_en  (mem_wr_byte_en),
    .mem_wr_data     (mem_wr_data),
    .mem_rd_data     (mem_rd_data)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] ram_init(input int i);
    return 32'hC0DE0000 + 32'(i) * 32'h01010101;
  endfunction

  // Synchronous-read RAM behind the arbiter.
  logic [31:0] ram [16];
  bit          ram_fill = 1'b1;
  always @(posedge Clk) begin
    if (ram_fill) begin
      for (int i = 0; i < 16; i++) ram[i] <= ram_init(i);
    end else if (mem_en) begin
      if (|mem_wr_byte_en) begin
        for (int b = 0; b < 4; b++)
          if (mem_wr_byte_en[b]) ram[mem_addr[5:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
      end else begin
        mem_rd_data <= ram[mem_addr[5:2]];
      end
    end
  end

  // Reference model state, expressed in terms of observable behaviour.
  int          total = 0;
  int          bad = 0;
  int          wait_n = 0;     // cycles port 1 has waited unserved
  bit          locked = 1'b0;  // port 1 owns the RAM
  int          beats = 0;      // port-1 beats taken while locked
  bit          pend_v = 1'b0;
  int          pend_port = 0;
  logic [31:0] pend_data = '0;
  logic [31:0] mdl_mem [16];
  int          last_g = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input req_t r0, input req_t r1, input bit lk, input bit rn);
    int          eg;
    bit          starved;
    req_t        w;
    logic [31:0] exp_addr;
    @(negedge Clk);
    Reset_n         = rn;
    req0_valid      = r0.v;    req1_valid      = r1.v;
    req0_addr       = r0.addr; req1_addr       = r1.addr;
    req0_wr_byte_en = r0.be;   req1_wr_byte_en = r1.be;
    req0_wr_data    = r0.data; req1_wr_data    = r1.data;
    req1_lock       = lk;
    #1;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    starved = r1.v && (wait_n >= STARVE_LIMIT);
`else
    starved = 1'b0;
`endif
    if (!rn)              eg = -1;
    else if (locked)      eg = r1.v ? 1 : -1;
    else if (starved)     eg = 1;
    else if (r0.v)        eg = 0;
    else if (r1.v)        eg = 1;
    else                  eg = -1;
    last_g = eg;
    w = (eg == 1) ? r1 : r0;
    exp_addr = {w.addr[31:2], 2'b00};
    chk("ready0", 32'(req0_ready), 32'(eg == 0));
    chk("ready1", 32'(req1_ready), 32'(eg == 1));
    chk("mem_en", 32'(mem_en), 32'(eg >= 0));
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_wr_data", mem_wr_data, w.data);
    chk("mem_be", 32'(mem_wr_byte_en), (eg >= 0) ? 32'(w.be) : 32'd0);
    chk("rsp0_valid", 32'(rsp0_valid), 32'(pend_v && pend_port == 0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(pend_v && pend_port == 1));
    chk("rsp0_data", rsp0_rd_data, (pend_v && pend_port == 0) ? pend_data : 32'd0);
    chk("rsp1_data", rsp1_rd_data, (pend_v && pend_port == 1) ? pend_data : 32'd0);
    if (!rn) begin
      locked = 1'b0; beats = 0; wait_n = 0; pend_v = 1'b0;
    end else begin
      pend_v = 1'b0;
      if (eg >= 0) begin
        if (w.be == 4'b0000) begin
          pend_v = 1'b1; pend_port = eg; pend_data = mdl_mem[w.addr[5:2]];
        end else begin
          for (int b = 0; b < 4; b++)
            if (w.be[b]) mdl_mem[w.addr[5:2]][8*b +: 8] = w.data[8*b +: 8];
        end
      end
      if (r1.v && eg != 1) wait_n = (wait_n < STARVE_LIMIT) ? wait_n + 1 : wait_n;
      else                 wait_n = 0;
      if (!locked) begin
        if (eg == 1 && lk) begin locked = 1'b1; beats = 0; end
      end else if (!r1.v) begin
        locked = 1'b0;
      end else begin
        beats++;
        if (!lk || beats >= LOCK_MAX) locked = 1'b0;
      end
    end
  endtask

  function automatic req_t mk(input bit v, input logic [31:0] a, input logic [3:0] be,
                              input logic [31:0] d);
    req_t r;
    r.v = v; r.addr = a; r.be = be; r.data = d;
    return r;
  endfunction

  function automatic req_t rnd_req(input int pct);
    return mk($urandom_range(99) < pct, $urandom,
              ($urandom_range(1) == 0) ? 4'b0000 : 4'($urandom), $urandom);
  endfunction

  req_t idle;
  int   g1_cnt, g1_first;
  int   r0_hist [6];

  initial begin
    for (int i = 0; i < 16; i++) mdl_mem[i] = ram_init(i);
    idle = mk(1'b0, 32'h0, 4'h0, 32'h0);

    // Reset with both ports requesting: nothing may be granted.
    for (int i = 0; i < 3; i++)
      step(mk(1'b1, 32'h40, 4'h0, 32'h1), mk(1'b1, 32'h80, 4'hF, 32'h2), 1'b1, 1'b0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    ram_fill = 1'b0;
    step(idle, idle, 1'b0, 1'b1);

    // Uncontested port-0 read.
    step(mk(1'b1, 32'h104, 4'h0, 32'h0), idle, 1'b0, 1'b1);
    chk("p0_rd_ready", 32'(req0_ready), 32'd1);
    chk("p0_rd_addr", mem_addr, 32'h104);
    step(idle, idle, 1'b0, 1'b1);
    chk("p0_rsp_valid", 32'(rsp0_valid), 32'd1);
    chk("p0_rsp_data", rsp0_rd_data, ram_init(1));

    // Both ports reading continuously.
    g1_cnt = 0; g1_first = -1;
    for (int i = 0; i < 50; i++) begin
      step(mk(1'b1, 32'h10, 4'h0, 32'h0), mk(1'b1, 32'h20, 4'h0, 32'h0), 1'b0, 1'b1);
      if (last_g == 1) begin
        if (g1_first < 0) g1_first = i;
        g1_cnt++;
      end
      if (req1_ready) begin
        if (i < 27 && g1_first < 0) g1_first = i;
      end
    end
`ifdef DMEM_ARB_STARVE_GUARD_EN
    chk("starve_first", 32'(g1_first), 32'(STARVE_LIMIT));
    chk("starve_count", 32'(g1_cnt), 32'(50 / (STARVE_LIMIT + 1)));
`else
    chk("starve_first", 32'(g1_first), 32'hFFFF_FFFF);
    chk("starve_count", 32'(g1_cnt), 32'd0);
`endif
    step(idle, idle, 1'b0, 1'b1);
    step(idle, idle, 1'b0, 1'b1);

    // Locked port-1 write burst while port 0 keeps requesting.
    step(idle, mk(1'b1, 32'h30, 4'hF, 32'hDEADBEEF), 1'b1, 1'b1);
    chk("lock_entry", 32'(req1_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step(mk(1'b1, 32'h34, 4'h0, 32'h0), mk(1'b1, 32'h30, 4'hF, 32'hDEADBEEF), 1'b1, 1'b1);
      r0_hist[i] = 32'(req0_ready);
    end
    chk("lock_hold", 32'(r0_hist[0] + r0_hist[1] + r0_hist[2] + r0_hist[3]), 32'd0);
    chk("lock_release", 32'(r0_hist[4]), 32'd1);
    step(idle, idle, 1'b0, 1'b1);
    step(mk(1'b1, 32'h30, 4'h0, 32'h0), idle, 1'b0, 1'b1);
    step(idle, idle, 1'b0, 1'b1);
    chk("lock_wr_data", rsp0_rd_data, 32'hDEADBEEF);

    // Alternating single-port reads.
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) step(mk(1'b1, 32'(4 * i), 4'h0, 32'h0), idle, 1'b0, 1'b1);
      else            step(idle, mk(1'b1, 32'(4 * i), 4'h0, 32'h0), 1'b0, 1'b1);
    end
    step(idle, idle, 1'b0, 1'b1);

    // Reset right after a port-1 read: the response must be dropped.
    step(idle, mk(1'b1, 32'h8, 4'h0, 32'h0), 1'b0, 1'b1);
    step(mk(1'b1, 32'h0, 4'h0, 32'h0), mk(1'b1, 32'h4, 4'h0, 32'h0), 1'b0, 1'b0);
    step(idle, idle, 1'b0, 1'b1);
    chk("rst_drop_rsp1", 32'(rsp1_valid), 32'd0);
    chk("rst_drop_data", rsp1_rd_data, 32'd0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++)
      step(rnd_req(60), rnd_req(55), $urandom_range(99) < 40, $urandom_range(99) >= 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
